// File: rtl/mix_state_unloader_if.sv
// mix_state_unloader_if
//   Bundles the block-load handshake (upstream mix layer) and the word
//   stream handshake (downstream round datapath) of mix_state_unloader.
//   master : block producer / word consumer side
//   slave  : the unloader itself
//   Signals: load_valid/load_ready/state_in/round_in (block in),
//            word_valid/word_ready/word_data/word_idx/word_round/word_last,
//            busy.
interface mix_state_unloader_if #(
   parameter int WORD_W    = 64,
   parameter int NUM_WORDS = 16
);
   localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   logic                        load_valid;
   logic                        load_ready;
   logic [WORD_W*NUM_WORDS-1:0] state_in;
   logic [7:0]                  round_in;
   logic                        word_valid;
   logic                        word_ready;
   logic [WORD_W-1:0]           word_data;
   logic [IDX_W-1:0]            word_idx;
   logic [7:0]                  word_round;
   logic                        word_last;
   logic                        busy;

   modport master (
      output load_valid, state_in, round_in, word_ready,
      input  load_ready, word_valid, word_data, word_idx, word_round,
             word_last, busy
   );

   modport slave (
      input  load_valid, state_in, round_in, word_ready,
      output load_ready, word_valid, word_data, word_idx, word_round,
             word_last, busy
   );
endinterface

// File: rtl/mix_state_unloader.sv
// mix_state_unloader
//   Captures one WORD_W*NUM_WORDS-bit mixed state plus its 8-bit round tag
//   into a shadow register and streams it out as NUM_WORDS words over a
//   valid/ready interface. With LSB_FIRST=0 word 0 is the top slice of the
//   state (mix-layer packing order); with LSB_FIRST=1 word 0 is the bottom.
//   A new block may be captured on the last-word handshake, so blocks can
//   stream back to back without a bubble.
//
//   Ports: clk, rst (synchronous, active high), bus (mix_state_unloader_if
//   slave modport: load handshake, word stream, busy).
//   Optional build macro MIX_UNLOAD_XOR_CHK_EN adds chk_valid/chk_word:
//   XOR of all words of a block, published with a one-cycle pulse after the
//   last-word handshake.
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | no block held, load_ready=1
//   SEND  | block held in shadow, presenting word idx
module mix_state_unloader #(
   parameter int WORD_W    = 64,
   parameter int NUM_WORDS = 16,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
`ifdef MIX_UNLOAD_XOR_CHK_EN
   output logic                chk_valid,
   output logic [WORD_W-1:0]   chk_word,
`endif
   mix_state_unloader_if.slave bus
);
   localparam int                STATE_W  = WORD_W * NUM_WORDS;
   localparam int                IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);

   typedef enum logic {ST_IDLE, ST_SEND} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [STATE_W-1:0] shadow_q, shadow_d;
   logic [7:0]         round_q, round_d;

   logic               in_send;
   logic               last_beat;
   logic               word_hs;
   logic               load_rdy;
   logic               capture;
   logic [IDX_W-1:0]   sel;
   logic [WORD_W-1:0]  cur_word;
   logic [WORD_W-1:0]  words [NUM_WORDS];

   for (genvar i = 0; i < NUM_WORDS; i++) begin : g_slice
      assign words[i] = shadow_q[i*WORD_W +: WORD_W];
   end

   // Word order is a pure index remap; the shadow is never shifted so the
   // presented word stays stable under backpressure.
   assign sel       = LSB_FIRST ? idx_q : (LAST_IDX - idx_q);
   assign cur_word  = words[sel];

   assign in_send   = (state_q == ST_SEND);
   assign last_beat = in_send && (idx_q == LAST_IDX);
   assign word_hs   = in_send && bus.word_ready;
   // Combinational path from word_ready: lets the next block be captured on
   // the last-word handshake.
   assign load_rdy  = !in_send || (last_beat && bus.word_ready);
   assign capture   = bus.load_valid && load_rdy;

   always_comb begin
      bus.load_ready = load_rdy;
      bus.word_valid = in_send;
      bus.busy       = in_send;
      bus.word_data  = cur_word;
      bus.word_idx   = idx_q;
      bus.word_round = round_q;
      bus.word_last  = last_beat;
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      round_d  = round_q;
      unique case (state_q)
         ST_IDLE: begin
            if (capture) state_d = ST_SEND;
         end
         ST_SEND: begin
            if (word_hs) begin
               if (!last_beat) idx_d = idx_q + IDX_W'(1);
               else if (!capture) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (capture) begin
         shadow_d = bus.state_in;
         round_d  = bus.round_in;
         idx_d    = '0;
      end
   end

`ifdef MIX_UNLOAD_XOR_CHK_EN
   logic [WORD_W-1:0] acc_q, acc_d;
   logic [WORD_W-1:0] chk_word_q, chk_word_d;
   logic              chk_valid_q, chk_valid_d;
   logic [WORD_W-1:0] acc_next;

   assign acc_next = acc_q ^ cur_word;

   always_comb begin
      acc_d       = acc_q;
      chk_word_d  = chk_word_q;
      chk_valid_d = word_hs && last_beat;
      if (word_hs)               acc_d      = acc_next;
      if (word_hs && last_beat)  chk_word_d = acc_next;
      // A capture on the last beat starts the next block from zero.
      if (capture)               acc_d      = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q       <= '0;
         chk_word_q  <= '0;
         chk_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         chk_word_q  <= chk_word_d;
         chk_valid_q <= chk_valid_d;
      end
   end

   assign chk_valid = chk_valid_q;
   assign chk_word  = chk_word_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         shadow_q <= '0;
         round_q  <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         round_q  <= round_d;
      end
   end
endmodule

// File: tb/tb_mix_state_unloader.sv
// tb_mix_state_unloader
//   Directed bench for mix_state_unloader: a scoreboard queue receives the
//   expected word stream whenever a block is accepted, and a negedge monitor
//   pops and compares on every word handshake and checks output stability
//   during stalls. A second instance with LSB_FIRST=1 checks word order.
module tb_mix_state_unloader;
   localparam int W = 64;
   localparam int N = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mix_state_unloader_if #(.WORD_W(W), .NUM_WORDS(N)) bus0 ();
   mix_state_unloader_if #(.WORD_W(W), .NUM_WORDS(N)) bus1 ();

`ifdef MIX_UNLOAD_XOR_CHK_EN
   logic          chk_valid0, chk_valid1;
   logic [W-1:0]  chk_word0, chk_word1;
`endif

   mix_state_unloader #(.WORD_W(W), .NUM_WORDS(N), .LSB_FIRST(1'b0)) dut0 (
      .clk       (clk),
      .rst       (rst),
`ifdef MIX_UNLOAD_XOR_CHK_EN
      .chk_valid (chk_valid0),
      .chk_word  (chk_word0),
`endif
      .bus       (bus0)
   );

   mix_state_unloader #(.WORD_W(W), .NUM_WORDS(N), .LSB_FIRST(1'b1)) dut1 (
      .clk       (clk),
      .rst       (rst),
`ifdef MIX_UNLOAD_XOR_CHK_EN
      .chk_valid (chk_valid1),
      .chk_word  (chk_word1),
`endif
      .bus       (bus1)
   );

   typedef struct packed {
      logic [63:0] d;
      logic [3:0]  idx;
      logic [7:0]  r;
      logic        last;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   hs_count = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Word j in mix-layer order (j=0 is the top slice) = base + j*step.
   function automatic logic [1023:0] mk_block(input logic [63:0] base, input logic [63:0] step);
      logic [1023:0] b;
      b = '0;
      for (int j = 0; j < N; j++) b[(N-1-j)*W +: W] = base + 64'(j) * step;
      return b;
   endfunction

   task automatic push_exp(input logic [1023:0] blk, input logic [7:0] rnd);
      exp_t e;
      for (int i = 0; i < N; i++) begin
         e.d    = blk[(N-1-i)*W +: W];
         e.idx  = 4'(i);
         e.r    = rnd;
         e.last = (i == N-1);
         sb.push_back(e);
      end
   endtask

   // Monitor for dut0: scoreboard pop on handshake, hold check on stall.
   exp_t cur, prev;
   bit   stalled = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         stalled = 1'b0;
      end else begin
         cur.d    = bus0.word_data;
         cur.idx  = bus0.word_idx;
         cur.r    = bus0.word_round;
         cur.last = bus0.word_last;
         if (stalled && bus0.word_valid) chk("stall_hold", 128'(cur), 128'(prev));
         if (bus0.word_valid && bus0.word_ready) begin
            hs_count++;
            chk("word_expected", 128'(sb.size() != 0), 128'(1));
            if (sb.size() != 0) chk("word", 128'(cur), 128'(sb.pop_front()));
         end
         stalled = bus0.word_valid && !bus0.word_ready;
         prev    = cur;
      end
   end

   // Entered and left at posedge+1.
   task automatic load(input logic [1023:0] blk, input logic [7:0] rnd, input bit keep,
                       output logic [3:0] a_idx, output logic a_last);
      bit ok;
      ok     = 1'b0;
      a_idx  = '0;
      a_last = 1'b0;
      bus0.load_valid = 1'b1;
      bus0.state_in   = blk;
      bus0.round_in   = rnd;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge clk);
         if (bus0.load_ready) begin
            ok     = 1'b1;
            a_idx  = bus0.word_idx;
            a_last = bus0.word_last;
         end
         @(posedge clk); #1;
      end
      chk("load_accept", 128'(ok), 128'(1));
      if (ok) push_exp(blk, rnd);
      if (!keep) bus0.load_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int k = 0; k < 400 && !done; k++) begin
         @(negedge clk);
         if (sb.size() == 0 && !bus0.busy) done = 1'b1;
      end
      chk("drain", 128'(done), 128'(1));
      @(posedge clk); #1;
   endtask

   task automatic wait_idx(input logic [3:0] target);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
         @(negedge clk);
         if (bus0.word_valid && bus0.word_idx == target) seen = 1'b1;
      end
      chk("reach_idx", 128'(seen), 128'(1));
      @(posedge clk); #1;
   endtask

   logic [3:0]    a_idx;
   logic          a_last;
   int            hs0;
   bit            done;
   logic [1023:0] blk;
   bit            pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   initial begin
      rst = 1'b1;
      bus0.load_valid = 1'b0; bus0.state_in = '0; bus0.round_in = '0; bus0.word_ready = 1'b0;
      bus1.load_valid = 1'b0; bus1.state_in = '0; bus1.round_in = '0; bus1.word_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_word_valid", 128'(bus0.word_valid), 128'(0));
      chk("rst_word_idx",   128'(bus0.word_idx),   128'(0));
      chk("rst_word_last",  128'(bus0.word_last),  128'(0));
      chk("rst_busy",       128'(bus0.busy),       128'(0));
      chk("rst_word_data",  128'(bus0.word_data),  128'(0));
      chk("rst_word_round", 128'(bus0.word_round), 128'(0));
      chk("rst_load_ready", 128'(bus0.load_ready), 128'(1));
`ifdef MIX_UNLOAD_XOR_CHK_EN
      chk("rst_chk_valid",  128'(chk_valid0),      128'(0));
      chk("rst_chk_word",   128'(chk_word0),       128'(0));
`endif
      @(posedge clk); #1;
      rst = 1'b0;

      // Basic stream: words 0..15, round 5, ready held high.
      bus0.word_ready = 1'b1;
      hs0 = hs_count;
      load(mk_block(64'h0, 64'h1), 8'h05, 1'b0, a_idx, a_last);
      @(negedge clk);
      chk("lat_valid", 128'(bus0.word_valid), 128'(1));
      chk("lat_idx",   128'(bus0.word_idx),   128'(0));
      chk("lat_data",  128'(bus0.word_data),  128'(0));
      repeat (16) @(negedge clk);
      chk("burst_drained",    128'(sb.size()),       128'(0));
      chk("burst_handshakes", 128'(hs_count - hs0),  128'(16));
      chk("burst_idle_valid", 128'(bus0.word_valid), 128'(0));
      chk("burst_load_ready", 128'(bus0.load_ready), 128'(1));
      @(posedge clk); #1;

      // Backpressure: ready pattern 1,0,0,1 repeating.
      bus0.word_ready = 1'b0;
      hs0 = hs_count;
      load(mk_block(64'h1111_0000_0000_0000, 64'h0101_0101_0101_0101), 8'h33, 1'b0, a_idx, a_last);
      done = 1'b0;
      for (int k = 0; k < 120 && !done; k++) begin
         bus0.word_ready = pat[k % 4];
         @(posedge clk); #1;
         if (sb.size() == 0 && !bus0.busy) done = 1'b1;
      end
      chk("bp_done",       128'(done),           128'(1));
      chk("bp_handshakes", 128'(hs_count - hs0), 128'(16));
      bus0.word_ready = 1'b1;
      @(posedge clk); #1;

      // Back-to-back: B captured on A's last handshake, no bubble.
      load(mk_block(64'hAAAA_0000_0000_0000, 64'h3), 8'h01, 1'b1, a_idx, a_last);
      load(mk_block(64'hBBBB_0000_0000_0000, 64'h5), 8'h02, 1'b0, a_idx, a_last);
      chk("b2b_cap_idx",  128'(a_idx),  128'(15));
      chk("b2b_cap_last", 128'(a_last), 128'(1));
      @(negedge clk);
      chk("b2b_valid", 128'(bus0.word_valid), 128'(1));
      chk("b2b_idx",   128'(bus0.word_idx),   128'(0));
      chk("b2b_round", 128'(bus0.word_round), 128'(8'h02));
      @(posedge clk); #1;
      wait_idle();

      // load_valid pulse mid-block is ignored.
      blk = mk_block(64'hC0C0_0000_0000_0000, 64'h7);
      load(blk, 8'h0C, 1'b0, a_idx, a_last);
      wait_idx(4'd2);
      bus0.load_valid = 1'b1;
      bus0.state_in   = ~blk;
      bus0.round_in   = 8'hEE;
      @(negedge clk);
      chk("midload_ready", 128'(bus0.load_ready), 128'(0));
      chk("midload_idx",   128'(bus0.word_idx),   128'(3));
      @(posedge clk); #1;
      bus0.load_valid = 1'b0;
      wait_idle();

      // Reset at idx 7.
      load(mk_block(64'hD000_0000_0000_0000, 64'h9), 8'h0D, 1'b0, a_idx, a_last);
      wait_idx(4'd6);
      chk("pre_rst_idx", 128'(bus0.word_idx), 128'(7));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("mrst_valid",      128'(bus0.word_valid), 128'(0));
      chk("mrst_busy",       128'(bus0.busy),       128'(0));
      chk("mrst_idx",        128'(bus0.word_idx),   128'(0));
      chk("mrst_load_ready", 128'(bus0.load_ready), 128'(1));
      chk("mrst_data",       128'(bus0.word_data),  128'(0));
      @(posedge clk); #1;
      load(mk_block(64'hE000_0000_0000_0000, 64'hB), 8'h0E, 1'b0, a_idx, a_last);
      @(negedge clk);
      chk("reload_valid", 128'(bus0.word_valid), 128'(1));
      chk("reload_idx",   128'(bus0.word_idx),   128'(0));
      @(posedge clk); #1;
      wait_idle();

`ifdef MIX_UNLOAD_XOR_CHK_EN
      // XOR of words 1..16 is 0x10.
      load(mk_block(64'h1, 64'h1), 8'h10, 1'b0, a_idx, a_last);
      repeat (15) @(posedge clk);
      #1;
      chk("xor_pre_pulse",  128'(chk_valid0), 128'(0));
      @(posedge clk); #1;
      chk("xor_pulse",      128'(chk_valid0), 128'(1));
      chk("xor_word",       128'(chk_word0),  128'(64'h10));
      @(posedge clk); #1;
      chk("xor_pulse_end",  128'(chk_valid0), 128'(0));
      wait_idle();
`endif

      // LSB_FIRST instance on the same words 1..16: 0x10 comes out first.
      bus1.word_ready = 1'b1;
      bus1.load_valid = 1'b1;
      bus1.state_in   = mk_block(64'h1, 64'h1);
      bus1.round_in   = 8'h07;
      @(negedge clk);
      chk("lsb_load_ready", 128'(bus1.load_ready), 128'(1));
      @(posedge clk); #1;
      bus1.load_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         chk("lsb_word", 128'({bus1.word_valid, bus1.word_idx, bus1.word_data}),
             128'({1'b1, 4'(i), 64'(16 - i)}));
      end
      @(posedge clk); #1;
`ifdef MIX_UNLOAD_XOR_CHK_EN
      chk("lsb_xor_pulse", 128'(chk_valid1), 128'(1));
      chk("lsb_xor_word",  128'(chk_word1),  128'(64'h10));
`endif
      chk("lsb_idle", 128'(bus1.word_valid), 128'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
